// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: byte handshake in, one-byte prefetch, MSB-first on miso.
// sclk and cs_n are oversampled in the clk domain; clk is the only clock.
module spi_slave_tx #(
  parameter logic [7:0]  FILL_BYTE   = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  output logic       miso,
  input  logic       tx_data_ready,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       frame_active,
  output logic [5:0] byte_count,
  output logic       underrun
);
  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] sclk_sync_r;
  logic [NS-1:0] cs_sync_r;
  logic          sclk_d_r;
  logic          cs_d_r;
  logic [NS:0]   settle_r;
  logic          armed_r;
  logic [7:0]    hold_data_r;
  logic          hold_full_r;
  logic [6:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          close_pend_r;

  logic       sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  logic       frame_start_s, frame_end_s, shift_evt_s, boundary_s, load_evt_s;
  logic       can_take_s, use_hold_s, bypass_s, use_fill_s, capture_s;
  logic       close_req_s, ack_next_s, close_pend_next_s;
  logic [7:0] load_byte_s;

  // Pin synchronizers, edge-detect registers and post-reset arming of the cs_n fall detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {NS{1'b0}};
      cs_sync_r   <= {NS{1'b1}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b1;
      settle_r    <= {(NS+1){1'b0}};
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[NS-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[NS-2:0], cs_n};
      sclk_d_r    <= sclk_sync_r[NS-1];
      cs_d_r      <= cs_sync_r[NS-1];
      settle_r    <= {settle_r[NS-1:0], 1'b1};
      // A frame may only start once a genuinely sampled cs_n high has been seen after reset.
      if (settle_r[NS] && cs_d_r && cs_sync_r[NS-1]) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Event decode, byte-source priority and handshake decisions.
  always_comb begin
    sclk_rise_s   = sclk_sync_r[NS-1] & ~sclk_d_r;
    sclk_fall_s   = ~sclk_sync_r[NS-1] & sclk_d_r;
    cs_fall_s     = armed_r & cs_d_r & ~cs_sync_r[NS-1];
    cs_rise_s     = ~cs_d_r & cs_sync_r[NS-1];
    frame_start_s = cs_fall_s & ~frame_active;
    frame_end_s   = cs_rise_s & frame_active;
    // Frame end beats a coincident sclk fall so a cleanly closed frame starts no extra byte.
    shift_evt_s   = frame_active & ~cs_rise_s & sclk_fall_s;
    boundary_s    = shift_evt_s & (bit_cnt_r == 3'd0);
    load_evt_s    = frame_start_s | boundary_s;
    can_take_s    = tx_data_ready & ~tx_ack;
    use_hold_s    = load_evt_s & hold_full_r;
    bypass_s      = load_evt_s & ~hold_full_r & can_take_s;
    use_fill_s    = load_evt_s & ~hold_full_r & ~can_take_s;
    capture_s     = (~hold_full_r | use_hold_s) & can_take_s & ~bypass_s;
    close_req_s   = frame_end_s | close_pend_r;
    ack_next_s    = capture_s | bypass_s | close_req_s;
    close_pend_next_s = close_req_s & (capture_s | bypass_s);
    if (use_hold_s) begin
      load_byte_s = hold_data_r;
    end else if (bypass_s) begin
      load_byte_s = tx_data;
    end else begin
      load_byte_s = FILL_BYTE;
    end
  end

  // Frame state, shifter, holding register and tx_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso         <= 1'b0;
      tx_ack       <= 1'b0;
      frame_active <= 1'b0;
      byte_count   <= 6'd0;
      underrun     <= 1'b0;
      hold_data_r  <= 8'h00;
      hold_full_r  <= 1'b0;
      shift_r      <= 7'd0;
      bit_cnt_r    <= 3'd0;
      close_pend_r <= 1'b0;
    end else begin
      tx_ack       <= ack_next_s;
      close_pend_r <= close_pend_next_s;
      if (capture_s) begin
        hold_data_r <= tx_data;
        hold_full_r <= 1'b1;
      end else if (use_hold_s) begin
        hold_full_r <= 1'b0;
      end
      if (frame_start_s) begin
        frame_active <= 1'b1;
        byte_count   <= 6'd1;
        underrun     <= use_fill_s;
        bit_cnt_r    <= 3'd0;
      end else if (frame_end_s) begin
        frame_active <= 1'b0;
        bit_cnt_r    <= 3'd0;
      end else begin
        if (frame_active && sclk_rise_s) begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        if (boundary_s) begin
          if (byte_count != 6'd63) begin
            byte_count <= byte_count + 6'd1;
          end
          if (use_fill_s) begin
            underrun <= 1'b1;
          end
        end
      end
      if (frame_end_s) begin
        miso <= 1'b0;
      end else if (load_evt_s) begin
        shift_r <= load_byte_s[6:0];
        miso    <= load_byte_s[7];
      end else if (shift_evt_s) begin
        shift_r <= {shift_r[5:0], 1'b0};
        miso    <= shift_r[6];
      end
    end
  end
endmodule
